// File: rtl/soc_system_pio_pkg.sv
// Shared register map for the soc_system PIO family.
// Holds the Avalon-MM word addresses used by the LED and button PIOs.
package soc_system_pio_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_BLINK    = 2'd1;
  localparam logic [1:0] ADDR_OUTSET   = 2'd2;
  localparam logic [1:0] ADDR_OUTCLEAR = 2'd3;

endpackage

// File: rtl/soc_system_led_pio_prescaler.sv
// Blink prescaler: toggles phase_o every BLINK_DIV cycles.
// Ports: clk, reset (async high), clr_i (sync restart, phase=1), phase_o.
module soc_system_led_pio_prescaler #(
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  output logic phase_o
);

  localparam int unsigned CW =
    (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  // A clear has priority over the terminal count.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clr_i) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == TERM) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/soc_system_led_pio.sv
// Avalon-MM LED output PIO with set/clear and optional blink.
// Ports: clk, reset, address, chipselect, write_n, writedata,
// readdata (registered), out_port (registered). Optional blink:
// SOC_SYSTEM_LED_PIO_BLINK_EN.
module soc_system_led_pio
  import soc_system_pio_pkg::*;
#(
  parameter int unsigned    WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned    BLINK_DIV   = 25000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic             wr_en;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] gate;
  logic [WIDTH-1:0] out_q, out_d;
  logic [31:0]      rd_q, rd_d;
  logic             unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  always_comb begin
    data_d = data_q;
    unique case (1'b1)
      wr_en && (address == ADDR_DATA):
        data_d = wd;
      wr_en && (address == ADDR_OUTSET):
        data_d = data_q | wd;
      wr_en && (address == ADDR_OUTCLEAR):
        data_d = data_q & ~wd;
      default: data_d = data_q;
    endcase
  end

`ifdef SOC_SYSTEM_LED_PIO_BLINK_EN
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             blink_wr;
  logic             phase;

  assign blink_wr = wr_en && (address == ADDR_BLINK);
  assign mask_d   = blink_wr ? wd : mask_q;

  soc_system_led_pio_prescaler #(
    .BLINK_DIV(BLINK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (blink_wr),
    .phase_o(phase)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mask_q <= '0;
    else       mask_q <= mask_d;
  end

  // Masked bits pass only while phase is high.
  assign gate = ~mask_q | {WIDTH{phase}};
`else
  assign gate = '1;
`endif

  assign out_d = data_q & gate;

  always_comb begin
    rd_d = '0;
    case (address)
      ADDR_DATA:  rd_d = 32'(data_q);
`ifdef SOC_SYSTEM_LED_PIO_BLINK_EN
      ADDR_BLINK: rd_d = 32'(mask_q);
`endif
      default:    rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= RESET_VALUE;
      out_q  <= RESET_VALUE;
      rd_q   <= '0;
    end else begin
      data_q <= data_d;
      out_q  <= out_d;
      rd_q   <= rd_d;
    end
  end

  assign out_port = out_q;
  assign readdata = rd_q;

endmodule

// File: tb/tb_soc_system_led_pio.sv
// Scoreboard bench for soc_system_led_pio.
// Model predicts out_port/readdata per edge; monitor checks at negedge.
module tb_soc_system_led_pio;

  localparam int unsigned W   = 8;
  localparam logic [7:0]  RV  = 8'hA5;
  localparam int unsigned DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  soc_system_led_pio #(
    .WIDTH(W),
    .RESET_VALUE(RV),
    .BLINK_DIV(DIV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  out;
    logic [31:0] rd;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference state: register contents plus cycles elapsed since
  // the blink timebase last restarted.
  logic [7:0] m_data = RV;
  logic [7:0] m_mask = '0;
  int         m_age  = 0;

  function automatic logic blink_on(input int age);
    return ((age / DIV) % 2) == 0;
  endfunction

  task automatic model_step();
    exp_t e;
    logic wr;
    logic [7:0] wd;
    if (reset) begin
      e.out = RV;
      e.rd  = '0;
      exp_q.push_back(e);
      m_data = RV;
      m_mask = '0;
      m_age  = 0;
      return;
    end
    e.out = m_data & (~m_mask | {8{blink_on(m_age)}});
    case (address)
      2'd0:    e.rd = {24'h0, m_data};
      2'd1:    e.rd = {24'h0, m_mask};
      default: e.rd = '0;
    endcase
    exp_q.push_back(e);
    wr = chipselect && !write_n;
    wd = writedata[7:0];
    m_age = m_age + 1;
    if (wr) begin
      case (address)
        2'd0: m_data = wd;
        2'd1: begin
`ifdef SOC_SYSTEM_LED_PIO_BLINK_EN
          m_mask = wd;
          m_age  = 0;
`endif
        end
        2'd2: m_data = m_data | wd;
        default: m_data = m_data & ~wd;
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (out_port !== e.out) begin
        n_fail++;
        $display("FAIL out_port t=%0t got %h want %h",
                 $time, out_port, e.out);
      end
      n_tests++;
      if (readdata !== e.rd) begin
        n_fail++;
        $display("FAIL readdata t=%0t got %h want %h",
                 $time, readdata, e.rd);
      end
    end
  end

  task automatic drive(input logic cs, input logic wn,
                       input logic [1:0] a,
                       input logic [31:0] d);
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = d;
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    drive(1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [1:0] a, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, a, '0);
  endtask

  task automatic async_reset_check();
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (out_port !== RV) begin
      n_fail++;
      $display("FAIL async_rst_out got %h want %h", out_port, RV);
    end
    n_tests++;
    if (readdata !== 32'h0) begin
      n_fail++;
      $display("FAIL async_rst_rd got %h want 0", readdata);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    rd(2'd0, 2);
    wr(2'd0, 32'hFFFF_FF3C);
    rd(2'd0, 2);
    wr(2'd2, 32'h81);
    wr(2'd3, 32'h0D);
    rd(2'd2, 1);
    rd(2'd3, 1);
    rd(2'd0, 2);
    wr(2'd2, 32'h0);
    wr(2'd3, 32'h0);
    drive(1'b0, 1'b0, 2'd0, 32'h55);
    rd(2'd0, 2);
    wr(2'd0, 32'hFF);
    wr(2'd1, 32'h0F);
    rd(2'd1, 6);
    wr(2'd1, 32'h0F);
    rd(2'd0, 12);
    wr(2'd1, 32'hFF);
    rd(2'd1, 2);
    wr(2'd1, 32'h0F);
    rd(2'd0, 5);
    async_reset_check();
    rd(2'd1, 3);
    rd(2'd0, 2);
    wr(2'd0, 32'h5A);
    rd(2'd0, 100);
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0,
            2'($urandom_range(0, 3)),
            $urandom);
      if (i == 200) async_reset_check();
    end
    rd(2'd0, 4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
